// File: rtl/temp_sensor_ctrl.sv
// Measurement sequencer for the ring-oscillator temperature sensor: settle, gate-count
// oscillator edges over 2^AVG_LOG2 windows, and publish the truncated average.
module temp_sensor_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned GATE_CYCLES   = 1024,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned AVG_LOG2      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             continuous,
    input  logic             osc_in,
    output logic             sensor_en,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             overflow
);

    localparam int unsigned TMAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned IW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned AW   = CNT_W + AVG_LOG2;

    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] GATE_LOAD   = TW'(GATE_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST    = IW'((2 ** AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        GATE,
        ACCUM,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             valid_q, valid_d;
    logic [2:0]       sync_q;
    logic             edge_q;

    // sync_q[0..1] is the two-flop synchronizer, sync_q[2] the previous sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], osc_in};
            edge_q <= sync_q[1] & ~sync_q[2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            ovf_acc_q  <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            ovf_acc_q  <= ovf_acc_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        ovf_acc_d  = ovf_acc_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start || continuous) begin
                    state_d   = SETTLE;
                    timer_d   = SETTLE_LOAD;
                    acc_d     = '0;
                    idx_d     = '0;
                    ovf_acc_d = 1'b0;
                end
            end
            SETTLE: begin
                if (timer_q == '0) begin
                    state_d = GATE;
                    timer_d = GATE_LOAD;
                    cnt_d   = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            GATE: begin
                if (edge_q) begin
                    if (&cnt_q) ovf_acc_d = 1'b1;
                    else        cnt_d     = cnt_q + CNT_W'(1);
                end
                if (timer_q == '0) state_d = ACCUM;
                else               timer_d = timer_q - TW'(1);
            end
            ACCUM: begin
                acc_d = acc_q + AW'(cnt_q);
                if (idx_q == IDX_LAST) begin
                    // Outputs are loaded on entry to DONE so the valid pulse coincides with DONE.
                    state_d    = DONE;
                    result_d   = CNT_W'(acc_d >> AVG_LOG2);
                    overflow_d = ovf_acc_d;
                    valid_d    = 1'b1;
                end else begin
                    state_d = GATE;
                    idx_d   = idx_q + IW'(1);
                    timer_d = GATE_LOAD;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                if (continuous) begin
                    state_d   = GATE;
                    acc_d     = '0;
                    idx_d     = '0;
                    ovf_acc_d = 1'b0;
                    timer_d   = GATE_LOAD;
                    cnt_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sensor_en    = (state_q != IDLE);
    assign busy         = (state_q != IDLE);
    assign result       = result_q;
    assign result_valid = valid_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_temp_sensor_ctrl.sv
// Bench for temp_sensor_ctrl: a CNT_W=8 and a CNT_W=2 instance, scoreboarded result_valid
// pulses with expected cycle, single-shot vector table and hand-written corner sequences.
module tb_temp_sensor_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, cont_a = 1'b0, osc_a = 1'b0;
    logic       start_b = 1'b0, cont_b = 1'b0, osc_b = 1'b0;
    logic       sensor_en_a, busy_a, valid_a, overflow_a;
    logic       sensor_en_b, busy_b, valid_b, overflow_b;
    logic [7:0] result_a;
    logic [1:0] result_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int ph     = 0;
    int mode_a = 2;  // 0 low, 1 high, 2 toggling with period 4
    int mode_b = 2;

    typedef struct {
        int res;
        int ovf;
        int cyc;
    } exp_t;
    exp_t q_a[$];
    exp_t q_b[$];

    typedef struct {
        bit    on_b;
        int    mode;
        int    res;
        int    ovf;
        string name;
    } vec_t;
    vec_t vt[5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ph = ph + 1;
        osc_a = (mode_a == 2) ? ph[1] : (mode_a == 1);
        osc_b = (mode_b == 2) ? ph[1] : (mode_b == 1);
    end

    temp_sensor_ctrl #(.SETTLE_CYCLES(4), .GATE_CYCLES(16), .CNT_W(8), .AVG_LOG2(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .continuous(cont_a), .osc_in(osc_a),
        .sensor_en(sensor_en_a), .busy(busy_a), .result(result_a),
        .result_valid(valid_a), .overflow(overflow_a)
    );

    temp_sensor_ctrl #(.SETTLE_CYCLES(4), .GATE_CYCLES(16), .CNT_W(2), .AVG_LOG2(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .continuous(cont_b), .osc_in(osc_b),
        .sensor_en(sensor_en_b), .busy(busy_b), .result(result_b),
        .result_valid(valid_b), .overflow(overflow_b)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input bit on_b, input int budget, input int want_cyc, input string nm);
        int n = 0;
        while ((on_b ? busy_b : busy_a) && n < budget) begin
            tick(1);
            n++;
        end
        check({nm, "_idle_cycle"}, cyc, want_cyc);
        check({nm, "_sensor_off"}, on_b ? sensor_en_b : sensor_en_a, 0);
    endtask

    task automatic push(input bit on_b, input int res, input int ovf, input int c);
        exp_t e;
        e.res = res;
        e.ovf = ovf;
        e.cyc = c;
        if (on_b) q_b.push_back(e);
        else      q_a.push_back(e);
    endtask

    // Scoreboard: every result_valid pulse must match the oldest pending expectation
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (valid_a) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_valid: got 1 expected 0 (cyc %0d)", cyc);
            end else begin
                e = q_a.pop_front();
                check("a_result", result_a, e.res);
                check("a_overflow", overflow_a, e.ovf);
                check("a_valid_cycle", cyc, e.cyc);
            end
        end
        if (valid_b) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_valid: got 1 expected 0 (cyc %0d)", cyc);
            end else begin
                e = q_b.pop_front();
                check("b_result", result_b, e.res);
                check("b_overflow", overflow_b, e.ovf);
                check("b_valid_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int c0;
        vt[0] = '{1'b0, 2, 4, 0, "a_toggle"};
        vt[1] = '{1'b0, 1, 0, 0, "a_stuck_high"};
        vt[2] = '{1'b0, 0, 0, 0, "a_low"};
        vt[3] = '{1'b1, 2, 3, 1, "b_saturate"};
        vt[4] = '{1'b1, 0, 0, 0, "b_low_after_sat"};

        tick(3);
        rst_n = 1'b1;
        tick(2);
        check("rst_sensor_en", sensor_en_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_result", result_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_overflow", overflow_a, 0);

        for (int i = 0; i < 5; i++) begin
            if (vt[i].on_b) mode_b = vt[i].mode;
            else            mode_a = vt[i].mode;
            tick(8);
            c0 = cyc;
            if (vt[i].on_b) start_b = 1'b1;
            else            start_a = 1'b1;
            push(vt[i].on_b, vt[i].res, vt[i].ovf, c0 + 73);
            tick(1);
            start_a = 1'b0;
            start_b = 1'b0;
            check({vt[i].name, "_busy"}, vt[i].on_b ? busy_b : busy_a, 1);
            check({vt[i].name, "_sensor_on"}, vt[i].on_b ? sensor_en_b : sensor_en_a, 1);
            wait_idle(vt[i].on_b, 120, c0 + 74, vt[i].name);
            check({vt[i].name, "_held_result"}, vt[i].on_b ? 32'(result_b) : 32'(result_a), vt[i].res);
        end

        // Starts while busy are neither honoured nor queued
        mode_a = 2;
        tick(8);
        c0 = cyc;
        start_a = 1'b1;
        push(1'b0, 4, 0, c0 + 73);
        tick(1);
        start_a = 1'b0;
        tick(9);
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(29);
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        wait_idle(1'b0, 120, c0 + 74, "ignored_start");
        tick(20);
        check("ignored_start_no_requeue", busy_a, 0);

        // Continuous run held across three pulses, dropped during the fourth measurement
        c0 = cyc;
        cont_a = 1'b1;
        push(1'b0, 4, 0, c0 + 73);
        push(1'b0, 4, 0, c0 + 142);
        push(1'b0, 4, 0, c0 + 211);
        push(1'b0, 4, 0, c0 + 280);
        tick(150);
        check("cont_busy_between", busy_a, 1);
        check("cont_sensor_between", sensor_en_a, 1);
        tick(70);
        cont_a = 1'b0;
        wait_idle(1'b0, 120, c0 + 281, "cont_long");

        // Continuous dropped at cycle 100: the running measurement completes, then IDLE
        tick(5);
        c0 = cyc;
        cont_a = 1'b1;
        push(1'b0, 4, 0, c0 + 73);
        push(1'b0, 4, 0, c0 + 142);
        tick(100);
        cont_a = 1'b0;
        wait_idle(1'b0, 120, c0 + 143, "cont_drop");
        tick(80);
        check("cont_drop_stays_idle", busy_a, 0);

        // Asynchronous reset mid-measurement
        c0 = cyc;
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        tick(29);
        check("pre_rst_result", result_a, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_sensor_en", sensor_en_a, 0);
        check("async_rst_busy", busy_a, 0);
        check("async_rst_result", result_a, 0);
        check("async_rst_valid", valid_a, 0);
        tick(2);
        rst_n = 1'b1;
        tick(120);
        check("post_rst_idle", busy_a, 0);

        check("queue_a_drained", q_a.size(), 0);
        check("queue_b_drained", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
